// File: rtl/mem_arbiter_n_if.sv
// mem_arbiter_n_if: bundle of master request/grant signals and the shared slave port.
//   master modport: used by the bench side (drives requests and slave read data).
//   slave modport : used by the arbiter (drives grants, read return and slave address/control).
interface mem_arbiter_n_if #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
);
    logic [N_MASTERS-1:0]        req_valid;
    logic [N_MASTERS*ADDR_W-1:0] req_addr;
    logic [N_MASTERS-1:0]        req_we;
    logic [N_MASTERS*DATA_W-1:0] req_wdata;
    logic [N_MASTERS-1:0]        gnt;
    logic [DATA_W-1:0]           rdata;
    logic [N_MASTERS-1:0]        rvalid;
    logic [ADDR_W-1:0]           slv_addr;
    logic                        slv_we;
    logic [DATA_W-1:0]           slv_wdata;
    logic [DATA_W-1:0]           slv_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, slv_rdata,
        input  gnt, rdata, rvalid, slv_addr, slv_we, slv_wdata
    );
    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, slv_rdata,
        output gnt, rdata, rvalid, slv_addr, slv_we, slv_wdata
    );
endinterface

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: fixed-priority N-master arbiter for a single memory slave with hold limit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_n_if.slave (requests in, grant/rvalid/rdata out, slave port)
//   Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter_n #(
    parameter int N_MASTERS  = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int HOLD_MAX   = 160,
    parameter int STARVE_MAX = 8
) (
    input logic clk,
    input logic rst,
    mem_arbiter_n_if.slave bus
);
    typedef enum logic {IDLE, OWNED} state_t;
    localparam int IW = $clog2(N_MASTERS);
    localparam int HW = $clog2(HOLD_MAX + 1);

    state_t               state_q;
    logic [IW-1:0]        owner_q;
    logic [N_MASTERS-1:0] gnt_q;
    logic [N_MASTERS-1:0] rvalid_q;
    logic [HW-1:0]        hold_q;

    logic [N_MASTERS-1:0] others;
    logic [IW-1:0]        win;
    logic                 own_req;
    logic                 force_ho;
    logic                 handover;

    function automatic logic [IW-1:0] lowest(input logic [N_MASTERS-1:0] m);
        lowest = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--)
            if (m[i]) lowest = IW'(i);
    endfunction

    // gnt_q is the owner's one-hot (zero in IDLE), so masking with it excludes the owner.
    assign others   = bus.req_valid & ~gnt_q;
    assign own_req  = |(bus.req_valid & gnt_q);
    // Hand over on the cycle the counter would reach HOLD_MAX so the owner keeps exactly HOLD_MAX cycles.
    assign force_ho = own_req && |others && hold_q == HW'(HOLD_MAX - 1);
    assign handover = state_q == OWNED && (!own_req || force_ho);

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0]        wait_q [N_MASTERS];
    logic [N_MASTERS-1:0] starved;

    always_comb begin
        starved = '0;
        for (int i = 0; i < N_MASTERS; i++) starved[i] = wait_q[i] >= SW'(STARVE_MAX);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_MASTERS; i++)
            if (rst || !bus.req_valid[i] || gnt_q[i]) wait_q[i] <= '0;
            else if (wait_q[i] != SW'(STARVE_MAX)) wait_q[i] <= wait_q[i] + SW'(1);
    end

    assign win = |(others & starved) ? lowest(others & starved) : lowest(others);
`else
    assign win = lowest(others);
`endif

    always_comb begin
        bus.slv_addr  = own_req ? bus.req_addr[owner_q*ADDR_W +: ADDR_W] : '0;
        bus.slv_we    = own_req ? bus.req_we[owner_q] : 1'b0;
        bus.slv_wdata = own_req ? bus.req_wdata[owner_q*DATA_W +: DATA_W] : '0;
    end

    // Slave read data arrives the cycle after the address, which is the rvalid cycle.
    assign bus.rdata  = |rvalid_q ? bus.slv_rdata : '1;
    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            hold_q   <= '0;
        end else begin
            rvalid_q <= (own_req && !bus.req_we[owner_q]) ? gnt_q : '0;
            if (state_q == IDLE || handover) begin
                hold_q  <= '0;
                state_q <= |others ? OWNED : IDLE;
                owner_q <= |others ? win : owner_q;
                gnt_q   <= |others ? N_MASTERS'(1) << win : '0;
            end else begin
                hold_q <= |others ? hold_q + HW'(1) : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed self-checking bench for mem_arbiter_n (two parameter sets).
module tb_mem_arbiter_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   g3    = 0;

    always #5 clk = ~clk;

    mem_arbiter_n_if #(.N_MASTERS(4), .ADDR_W(16), .DATA_W(8)) ia ();
    mem_arbiter_n_if #(.N_MASTERS(4), .ADDR_W(16), .DATA_W(8)) ib ();

    mem_arbiter_n #(.N_MASTERS(4), .ADDR_W(16), .DATA_W(8), .HOLD_MAX(4), .STARVE_MAX(3))
        dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    mem_arbiter_n #(.N_MASTERS(4), .ADDR_W(16), .DATA_W(8), .HOLD_MAX(2), .STARVE_MAX(3))
        dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia.req_valid = '0; ia.req_addr = '0; ia.req_we = '0; ia.req_wdata = '0; ia.slv_rdata = '0;
        ib.req_valid = '0; ib.req_addr = '0; ib.req_we = '0; ib.req_wdata = '0; ib.slv_rdata = '0;
        tick; tick;
        chk("rst_gnt", ia.gnt, 0);
        chk("rst_rvalid", ia.rvalid, 0);
        chk("rst_rdata", ia.rdata, 8'hFF);
        chk("rst_we", ia.slv_we, 0);
        chk("rst_addr", ia.slv_addr, 0);
        rst = 1'b0;

        // masters 0 (write) and 2 (read) request together
        ia.req_addr  = {16'h0000, 16'h2222, 16'h0000, 16'h1000};
        ia.req_wdata = {8'h00, 8'h00, 8'h00, 8'h11};
        ia.req_we    = 4'b0001;
        ia.req_valid = 4'b0101;
        tick;
        chk("prio_gnt", ia.gnt, 4'b0001);
        chk("own_addr", ia.slv_addr, 16'h1000);
        chk("own_we", ia.slv_we, 1);
        chk("own_wdata", ia.slv_wdata, 8'h11);
        tick;
        chk("no_preempt", ia.gnt, 4'b0001);
        chk("wr_no_rvalid", ia.rvalid, 0);
        ia.req_valid = 4'b0100;
        #1;
        chk("drop_addr0", ia.slv_addr, 0);
        chk("drop_we0", ia.slv_we, 0);
        tick;
        chk("rearb_gnt", ia.gnt, 4'b0100);
        chk("m2_addr", ia.slv_addr, 16'h2222);
        tick;
        ia.slv_rdata = 8'h3C;
        #1;
        chk("m2_rvalid", ia.rvalid, 4'b0100);
        chk("m2_rdata", ia.rdata, 8'h3C);
        ia.req_valid = 4'b0000;
        tick;
        chk("idle_gnt", ia.gnt, 0);
        chk("idle_rvalid", ia.rvalid, 0);
        chk("idle_rdata", ia.rdata, 8'hFF);

        // owner 1 reads C123, slave answers 5A
        ia.req_addr  = {16'h0000, 16'h0000, 16'hC123, 16'h0000};
        ia.req_we    = 4'b0000;
        ia.req_valid = 4'b0010;
        tick;
        chk("m1_gnt", ia.gnt, 4'b0010);
        chk("m1_addr", ia.slv_addr, 16'hC123);
        chk("m1_we", ia.slv_we, 0);
        tick;
        ia.slv_rdata = 8'h5A;
        #1;
        chk("m1_rvalid", ia.rvalid, 4'b0010);
        chk("m1_rdata", ia.rdata, 8'h5A);
        ia.req_valid = 4'b0000;
        tick;
        chk("m1_after_rvalid", ia.rvalid, 0);
        chk("m1_after_rdata", ia.rdata, 8'hFF);

        // hold limit: master 0 continuous, master 3 waiting
        ia.req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("hold_gnt0_%0d", i), ia.gnt, 4'b0001);
        end
        tick;
        chk("hold_handover", ia.gnt, 4'b1000);
        tick;
        chk("hold_keep3", ia.gnt, 4'b1000);
        ia.req_valid = 4'b0000;
        tick;
        chk("hold_idle", ia.gnt, 0);

        // reset while owner 2 writes
        ia.req_we    = 4'b0100;
        ia.req_wdata = {8'h00, 8'hAB, 8'h00, 8'h00};
        ia.req_valid = 4'b0100;
        tick;
        chk("w2_gnt", ia.gnt, 4'b0100);
        chk("w2_we", ia.slv_we, 1);
        chk("w2_wdata", ia.slv_wdata, 8'hAB);
        rst = 1'b1;
        tick;
        chk("mid_rst_gnt", ia.gnt, 0);
        chk("mid_rst_we", ia.slv_we, 0);
        chk("mid_rst_rvalid", ia.rvalid, 0);
        rst = 1'b0;
        tick;
        chk("post_rst_gnt", ia.gnt, 4'b0100);
        ia.req_valid = 4'b0000;
        tick;

        // HOLD_MAX=2 instance: masters 0, 1, 3 continuous
        ib.req_valid = 4'b1011;
        tick; chk("b_e1", ib.gnt, 4'b0001);
        tick; chk("b_e2", ib.gnt, 4'b0001);
        tick; chk("b_e3", ib.gnt, 4'b0010);
        tick; chk("b_e4", ib.gnt, 4'b0010);
        tick;
`ifdef ARB_STARVE_GUARD_EN
        chk("b_e5", ib.gnt, 4'b1000);
`else
        chk("b_e5", ib.gnt, 4'b0001);
`endif
        for (int i = 0; i < 100; i++) begin
            if (ib.gnt[3]) g3++;
            tick;
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("b_m3_granted", 32'(g3 > 0), 1);
`else
        chk("b_m3_never", g3, 0);
`endif
        ib.req_valid = 4'b0000;
        tick;
        chk("b_idle", ib.gnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
